// File: rtl/instr_fetch.sv
// Instruction fetch stage plus IF/ID register: owns the PC, issues word reads to a 1-cycle sync imem.
// Latency: instruction visible in IF/ID two cycles after its fetch address is issued; one per cycle steady state.
// Backpressure: hazard_detected holds IF/ID and PC; a 1-entry skid catches the response already in flight.
module instr_fetch #(
    parameter int unsigned               ADDRESS_WIDTH = 32,
    parameter int unsigned               DATA          = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0,
    parameter logic [DATA-1:0]           NOP_INSTR     = DATA'(32'hFC00_0000)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hazard_detected,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic                     halt_signal,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA-1:0]          imem_rdata,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [DATA-1:0]          instruction,
    output logic                     instr_valid,
    output logic [31:0]              fetch_count,
    output logic [31:0]              stall_count
);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_STALL    = 2'd1,
        S_REDIRECT = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic                     epoch;

    // Request issued last cycle; its data is on imem_rdata this cycle.
    logic                     inflight;
    logic                     inflight_epoch;
    logic [ADDRESS_WIDTH-1:0] inflight_pc;

    // One-entry skid for the response that lands while decode is stalled.
    logic                     skid_vld;
    logic [ADDRESS_WIDTH-1:0] skid_pc;
    logic [DATA-1:0]          skid_dat;

    logic halting;
    logic issue;
    logic resp_vld;
    logic load_vld;

    // Issue decision and response qualification; the epoch bit drops responses fetched before a redirect.
    always_comb begin
        halting  = halt_signal || (state == S_HALTED);
        issue    = !rst && !halting && !hazard_detected;
        resp_vld = inflight && (inflight_epoch == epoch) && !halting;
        load_vld = !rst && !branch_taken && !halting && !hazard_detected && (skid_vld || resp_vld);
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    // PC, epoch, skid, IF/ID register, state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_FETCH;
            fetch_pc       <= RESET_PC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= RESET_PC;
            skid_vld       <= 1'b0;
            skid_pc        <= RESET_PC;
            skid_dat       <= NOP_INSTR;
            pc             <= RESET_PC;
            instruction    <= NOP_INSTR;
            instr_valid    <= 1'b0;
            fetch_count    <= '0;
            stall_count    <= '0;
        end else begin
            inflight       <= issue;
            inflight_epoch <= epoch;
            inflight_pc    <= fetch_pc;
            fetch_count    <= fetch_count + 32'(load_vld);
            stall_count    <= stall_count + 32'(hazard_detected && instr_valid);

            if (branch_taken) begin
                // Redirect wins over stall and halt; flush everything fetched so far.
                fetch_pc    <= branch_target & ~ADDRESS_WIDTH'(3);
                epoch       <= ~epoch;
                skid_vld    <= 1'b0;
                instruction <= NOP_INSTR;
                instr_valid <= 1'b0;
                state       <= S_REDIRECT;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
                end

                if (halting) begin
                    // HALT sits in IF/ID; once decode takes it, present bubbles forever.
                    skid_vld <= 1'b0;
                    if (!hazard_detected) begin
                        instruction <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end
                    state <= S_HALTED;
                end else if (hazard_detected) begin
                    if (resp_vld) begin
                        skid_vld <= 1'b1;
                        skid_pc  <= inflight_pc;
                        skid_dat <= imem_rdata;
                    end
                    state <= S_STALL;
                end else begin
                    if (skid_vld) begin
                        pc          <= skid_pc;
                        instruction <= skid_dat;
                        instr_valid <= 1'b1;
                        skid_vld    <= resp_vld;
                        skid_pc     <= inflight_pc;
                        skid_dat    <= imem_rdata;
                    end else if (resp_vld) begin
                        pc          <= inflight_pc;
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                    end else begin
                        instruction <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end
                    state <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by randomized stall/branch traffic.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: hazard_detected driven by the bench; imem modelled as a 1-cycle synchronous ROM.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_detected;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_signal;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .halt_signal     (halt_signal),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .pc              (pc),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
    );

    // Memory contents: each word is derived from its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0400_0000;
    endfunction

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Advance until IF/ID holds a valid instruction, bounded; n = cycles waited.
    task automatic wait_valid(input string tag, input int bound, output int n);
        n = 0;
        while (!instr_valid && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] cur_pc;
        logic [31:0] exp_fetch;
        logic [31:0] exp_stall;
        int          bubbles;
        logic        hz;

        rst = 1'b1; hazard_detected = 1'b0; branch_taken = 1'b0;
        branch_target = '0; halt_signal = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instruction, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_fcnt", fetch_count, 32'd0);
        chk("rst_scnt", stall_count, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);

        // Stream start: issue at 0, first valid two cycles later
        rst = 1'b0; settle();
        chk("start_req", 32'(imem_req), 32'd1);
        chk("start_addr", imem_addr, 32'h0);
        tick();
        chk("c1_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("c2_valid", 32'(instr_valid), 32'd1);
        chk("c2_pc", pc, 32'h0);
        chk("c2_instr", instruction, 32'h0400_0000);
        tick();
        chk("c3_pc", pc, 32'h4);
        chk("c3_instr", instruction, 32'h0400_0004);
        tick();
        chk("c4_pc", pc, 32'h8);
        chk("c4_instr", instruction, 32'h0400_0008);
        chk("c4_fcnt", fetch_count, 32'd3);

        // Two-cycle stall at pc=8
        hazard_detected = 1'b1; tick();
        chk("stall1_pc", pc, 32'h8);
        settle();
        chk("stall1_req", 32'(imem_req), 32'd0);
        tick();
        chk("stall2_pc", pc, 32'h8);
        hazard_detected = 1'b0; tick();
        chk("rel_pc", pc, 32'hC);
        chk("rel_instr", instruction, mem_word(32'hC));
        chk("rel_scnt", stall_count, 32'd2);
        chk("rel_fcnt", fetch_count, 32'd4);
        tick();
        chk("rel2_pc", pc, 32'h10);
        chk("rel2_valid", 32'(instr_valid), 32'd1);

        // Branch to 0x102 while pc=16
        branch_taken = 1'b1; branch_target = 32'h102; tick();
        branch_taken = 1'b0;
        chk("br_bubble_valid", 32'(instr_valid), 32'd0);
        chk("br_bubble_instr", instruction, NOP);
        tick();
        wait_valid("br_timeout", 8, n);
        chk("br_latency", 32'(n), 32'd1);
        chk("br_pc", pc, 32'h100);
        chk("br_instr", instruction, mem_word(32'h100));

        // Fill skid, then branch with simultaneous hazard
        hazard_detected = 1'b1; tick();
        chk("skid_hold_pc", pc, 32'h100);
        branch_taken = 1'b1; branch_target = 32'h200; tick();
        branch_taken = 1'b0; hazard_detected = 1'b0;
        chk("brhz_valid", 32'(instr_valid), 32'd0);
        wait_valid("brhz_timeout", 8, n);
        chk("brhz_latency", 32'(n), 32'd2);
        chk("brhz_pc", pc, 32'h200);
        chk("brhz_instr", instruction, mem_word(32'h200));

        // Run to 0x20 and halt there
        branch_taken = 1'b1; branch_target = 32'h14; tick();
        branch_taken = 1'b0;
        wait_valid("halt_pre_timeout", 8, n);
        chk("halt_pre_pc", pc, 32'h14);
        tick(); tick(); tick();
        chk("halt_pc", pc, 32'h20);
        chk("halt_fcnt", fetch_count, 32'd11);
        chk("halt_scnt", stall_count, 32'd4);
        halt_signal = 1'b1; settle();
        chk("halt_req", 32'(imem_req), 32'd0);
        tick();
        halt_signal = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("halted_req", 32'(imem_req), 32'd0);
            chk("halted_valid", 32'(instr_valid), 32'd0);
            chk("halted_fcnt", fetch_count, 32'd11);
            tick();
        end
        branch_taken = 1'b1; branch_target = 32'h40; tick();
        branch_taken = 1'b0;
        wait_valid("unhalt_timeout", 8, n);
        chk("unhalt_latency", 32'(n), 32'd2);
        chk("unhalt_pc", pc, 32'h40);
        chk("unhalt_instr", instruction, mem_word(32'h40));

        // Randomized stalls and branches against an in-order stream model
        cur_pc = 32'h40; exp_fetch = 32'd12; exp_stall = 32'd4; bubbles = 0;
        for (int i = 0; i < 300; i++) begin
            if (bubbles > 0) begin
                chk("rnd_bubble", 32'(instr_valid), 32'd0);
                hazard_detected = 1'b0; branch_taken = 1'b0;
                if (bubbles == 1) exp_fetch++;
                bubbles--;
            end else begin
                chk("rnd_valid", 32'(instr_valid), 32'd1);
                chk("rnd_pc", pc, cur_pc);
                chk("rnd_instr", instruction, mem_word(cur_pc));
                chk("rnd_fcnt", fetch_count, exp_fetch);
                chk("rnd_scnt", stall_count, exp_stall);
                hz = ($urandom_range(0, 2) == 0);
                hazard_detected = hz;
                if (hz) exp_stall++;
                if ($urandom_range(0, 15) == 0) begin
                    branch_target = $urandom_range(0, 65535);
                    branch_taken  = 1'b1;
                    cur_pc  = branch_target & ~32'h3;
                    bubbles = 2;
                end else begin
                    branch_taken = 1'b0;
                    if (!hz) begin
                        cur_pc = cur_pc + 32'd4;
                        exp_fetch++;
                    end
                end
            end
            tick();
        end
        hazard_detected = 1'b0; branch_taken = 1'b0;
        wait_valid("rnd_end_timeout", 8, n);

        // PC wraps at the top of the address space
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFF9; tick();
        branch_taken = 1'b0;
        wait_valid("wrap_timeout", 8, n);
        chk("wrap_pc0", pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap_pc1", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", pc, 32'h0);
        chk("wrap_instr2", instruction, mem_word(32'h0));

        // Reset during a stall with the skid full
        hazard_detected = 1'b1; tick();
        rst = 1'b1; settle();
        chk("mrst_req", 32'(imem_req), 32'd0);
        tick();
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_instr", instruction, NOP);
        chk("mrst_fcnt", fetch_count, 32'd0);
        chk("mrst_scnt", stall_count, 32'd0);
        rst = 1'b0; hazard_detected = 1'b0; settle();
        chk("mrst_req2", 32'(imem_req), 32'd1);
        chk("mrst_addr", imem_addr, 32'h0);
        tick();
        chk("mrst_c1_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("mrst_c2_valid", 32'(instr_valid), 32'd1);
        chk("mrst_c2_pc", pc, 32'h0);
        chk("mrst_c2_instr", instruction, mem_word(32'h0));
        tick();
        chk("mrst_c3_pc", pc, 32'h4);
        chk("mrst_c3_fcnt", fetch_count, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
